// File: rtl/pooling_sched_pkg.sv
// pooling_sched_pkg: shared state encoding, error code and default widths for pooling_2d_sched.
// Rev 1.0
`default_nettype none

package pooling_sched_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DIM_WIDTH  = 12;
  localparam int DEF_K_WIDTH    = 4;

  localparam logic ERR_BAD_CFG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pooling_2d_sched_cnt.sv
// pooling_2d_sched_cnt: nested kc/kr/col0/row0 window walker with incremental address accumulators.
// POOL_SCHED_CEIL_EN selects clipped (ceil) windows. Rev 1.0
`default_nettype none

module pooling_2d_sched_cnt
  import pooling_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] sw_i,
  input  logic [DIM_WIDTH-1:0]  w_i,
  input  logic [DIM_WIDTH-1:0]  h_i,
  input  logic [K_WIDTH-1:0]    k_i,
  input  logic [K_WIDTH-1:0]    s_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  final_o
);

  localparam int EW = DIM_WIDTH + 1;

  logic [K_WIDTH-1:0]    kc_q, kc_d, kr_q, kr_d;
  logic [DIM_WIDTH-1:0]  col0_q, col0_d, row0_q, row0_d;
  logic [ADDR_WIDTH-1:0] krw_q, krw_d, rb_q, rb_d;
  logic [EW-1:0]         col_e, row_e, w_e, h_e, k_e, s_e;
  logic                  kc_end, kr_end, col_more, row_more;

  assign col_e = EW'(col0_q);
  assign row_e = EW'(row0_q);
  assign w_e   = EW'(w_i);
  assign h_e   = EW'(h_i);
  assign k_e   = EW'(k_i);
  assign s_e   = EW'(s_i);

`ifdef POOL_SCHED_CEIL_EN
  // Windows are clipped at the right/bottom map edge.
  assign kc_end   = (kc_q + K_WIDTH'(1) == k_i) || (col_e + EW'(kc_q) + EW'(1) == w_e);
  assign kr_end   = (kr_q + K_WIDTH'(1) == k_i) || (row_e + EW'(kr_q) + EW'(1) == h_e);
  assign col_more = (col_e + s_e) < w_e;
  assign row_more = (row_e + s_e) < h_e;
`else
  assign kc_end   = (kc_q + K_WIDTH'(1) == k_i);
  assign kr_end   = (kr_q + K_WIDTH'(1) == k_i);
  assign col_more = (col_e + s_e + k_e) <= w_e;
  assign row_more = (row_e + s_e + k_e) <= h_e;
`endif

  assign last_o  = kc_end & kr_end;
  assign final_o = last_o & ~col_more & ~row_more;
  assign addr_o  = rb_q + krw_q + ADDR_WIDTH'(col0_q) + ADDR_WIDTH'(kc_q);

  always_comb begin
    kc_d   = kc_q;
    kr_d   = kr_q;
    col0_d = col0_q;
    row0_d = row0_q;
    krw_d  = krw_q;
    rb_d   = rb_q;
    if (load_i) begin
      kc_d   = '0;
      kr_d   = '0;
      col0_d = '0;
      row0_d = '0;
      krw_d  = '0;
      rb_d   = base_i;
    end else if (step_i) begin
      if (!kc_end) begin
        kc_d = kc_q + K_WIDTH'(1);
      end else begin
        kc_d = '0;
        if (!kr_end) begin
          kr_d  = kr_q + K_WIDTH'(1);
          krw_d = krw_q + ADDR_WIDTH'(w_i);
        end else begin
          kr_d  = '0;
          krw_d = '0;
          if (col_more) begin
            col0_d = col0_q + DIM_WIDTH'(s_i);
          end else begin
            col0_d = '0;
            row0_d = row0_q + DIM_WIDTH'(s_i);
            rb_d   = rb_q + sw_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kc_q <= '0; kr_q <= '0; col0_q <= '0; row0_q <= '0; krw_q <= '0; rb_q <= '0;
    end else if (clr_i) begin
      kc_q <= '0; kr_q <= '0; col0_q <= '0; row0_q <= '0; krw_q <= '0; rb_q <= '0;
    end else begin
      kc_q <= kc_d; kr_q <= kr_d; col0_q <= col0_d; row0_q <= row0_d; krw_q <= krw_d; rb_q <= rb_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pooling_2d_sched.sv
// pooling_2d_sched: max-pooling address sequencer (job FSM, config check, result counting).
// POOL_SCHED_CEIL_EN drops the K>W / K>H checks and enables clipped windows. Rev 1.0
`default_nettype none

module pooling_2d_sched
  import pooling_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
  parameter int K_WIDTH    = DEF_K_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_i,
  input  logic                  go_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [DIM_WIDTH-1:0]  cfg_width_i,
  input  logic [DIM_WIDTH-1:0]  cfg_height_i,
  input  logic [K_WIDTH-1:0]    cfg_kernel_i,
  input  logic [K_WIDTH-1:0]    cfg_stride_i,
  output logic [ADDR_WIDTH-1:0] addr_data_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic                  addr_last_o,
  input  logic                  res_valid_i,
  input  logic                  res_ready_i,
  input  logic                  res_last_i
);

  localparam int CW = 2 * DIM_WIDTH + 1;

  state_e                state_q;
  logic                  busy_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0] base_q, sw_q;
  logic [DIM_WIDTH-1:0]  w_q, h_q;
  logic [K_WIDTH-1:0]    k_q, s_q, sc_q;
  logic [CW-1:0]         win_q, res_q;
  logic                  hs, load, cnt_last, cnt_final, cfg_bad, res_beat;

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign addr_valid_o = (state_q == ST_RUN);
  assign addr_last_o  = addr_valid_o & cnt_last;
  assign hs           = addr_valid_o & addr_ready_i;
  assign load         = (state_q == ST_SETUP) && (sc_q == s_q);
  assign res_beat     = res_valid_i & res_ready_i & res_last_i;

`ifdef POOL_SCHED_CEIL_EN
  assign cfg_bad = (k_q == '0) || (s_q == '0);
`else
  assign cfg_bad = (k_q == '0) || (s_q == '0) ||
                   (DIM_WIDTH'(k_q) > w_q) || (DIM_WIDTH'(k_q) > h_q);
`endif

  pooling_2d_sched_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_WIDTH (DIM_WIDTH),
    .K_WIDTH   (K_WIDTH)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (init_i),
    .load_i (load),
    .step_i (hs),
    .base_i (base_q),
    .sw_i   (sw_q),
    .w_i    (w_q),
    .h_i    (h_q),
    .k_i    (k_q),
    .s_i    (s_q),
    .addr_o (addr_data_o),
    .last_o (cnt_last),
    .final_o(cnt_final)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE; busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
      base_q <= '0; sw_q <= '0; w_q <= '0; h_q <= '0; k_q <= '0; s_q <= '0;
      sc_q <= '0; win_q <= '0; res_q <= '0;
    end else if (init_i) begin
      state_q <= ST_IDLE; busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
      base_q <= '0; sw_q <= '0; w_q <= '0; h_q <= '0; k_q <= '0; s_q <= '0;
      sc_q <= '0; win_q <= '0; res_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && res_beat) res_q <= res_q + CW'(1);
      case (state_q)
        ST_IDLE: begin
          if (go_i) begin
            base_q  <= cfg_base_i;
            w_q     <= cfg_width_i;
            h_q     <= cfg_height_i;
            k_q     <= cfg_kernel_i;
            s_q     <= cfg_stride_i;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            sc_q    <= '0;
            sw_q    <= '0;
            win_q   <= '0;
            res_q   <= '0;
            state_q <= ST_SETUP;
          end
        end
        // S*W is built by S additions of W, one per cycle, before RUN.
        ST_SETUP: begin
          if (sc_q == '0 && cfg_bad) begin
            error_q <= ERR_BAD_CFG;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else if (sc_q == s_q) begin
            state_q <= ST_RUN;
          end else begin
            sw_q <= sw_q + ADDR_WIDTH'(w_q);
            sc_q <= sc_q + K_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (hs) begin
            if (cnt_last)  win_q   <= win_q + CW'(1);
            if (cnt_final) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (res_q == win_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pooling_2d_sched.sv
// tb_pooling_2d_sched: scoreboard bench for pooling_2d_sched; POOL_SCHED_CEIL_EN swaps in the ceil-mode vectors.
// Rev 1.0
`default_nettype none

module tb_pooling_2d_sched;

  logic        clk = 1'b0, rst_n = 1'b0, init = 1'b0, go = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [11:0] cfg_w = '0, cfg_h = '0;
  logic [3:0]  cfg_k = '0, cfg_s = '0;
  logic        ready = 1'b1, res_v = 1'b0, res_r = 1'b0, res_l = 1'b0;
  logic        busy, done, error, valid, last;
  logic [31:0] addr;

  typedef struct packed {
    logic [31:0] a;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          n_checks = 0, n_pass = 0, done_cnt = 0;
  logic        tog_en = 1'b0, stall_pend = 1'b0;
  logic [31:0] stall_addr = '0;

  always #5 clk = ~clk;

  pooling_2d_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_i      (init),
    .go_i        (go),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .cfg_base_i  (cfg_base),
    .cfg_width_i (cfg_w),
    .cfg_height_i(cfg_h),
    .cfg_kernel_i(cfg_k),
    .cfg_stride_i(cfg_s),
    .addr_data_o (addr),
    .addr_valid_o(valid),
    .addr_ready_i(ready),
    .addr_last_o (last),
    .res_valid_i (res_v),
    .res_ready_i (res_r),
    .res_last_i  (res_l)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every address handshake.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (stall_pend && valid) chk("stall_hold", 64'(addr), 64'(stall_addr));
    stall_pend = valid && !ready;
    stall_addr = addr;
    if (valid && ready) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("addr", 64'(addr), 64'(mon_e.a));
        chk("last", 64'(last), 64'(mon_e.l));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (tog_en) ready = ~ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_t1();
    logic [31:0] tbl [16];
    logic [15:0] lm;
    beat_t       b;
    tbl = '{32'h100, 32'h101, 32'h104, 32'h105, 32'h102, 32'h103, 32'h106, 32'h107,
            32'h108, 32'h109, 32'h10C, 32'h10D, 32'h10A, 32'h10B, 32'h10E, 32'h10F};
    lm  = 16'h8888;
    for (int i = 0; i < 16; i++) begin
      b.a = tbl[i];
      b.l = lm[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic push_win(input int base, input int w, input int c0, input int r0, input int k);
    beat_t b;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++) begin
        b.a = 32'(base + (r0 + r) * w + c0 + c);
        b.l = (r == k - 1) && (c == k - 1);
        exp_q.push_back(b);
      end
  endtask

  // Pulses GO and returns the cycle count until ADDR_VALID or DONE shows up.
  task automatic start_job(input logic [31:0] b, input logic [11:0] w, input logic [11:0] h,
                           input logic [3:0] k, input logic [3:0] s, output int lat);
    @(posedge clk); #1;
    cfg_base = b; cfg_w = w; cfg_h = h; cfg_k = k; cfg_s = s; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid || done) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_drained(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic send_res(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      res_v = 1'b1; res_r = 1'b1; res_l = 1'b1;
      @(posedge clk); #1;
      res_v = 1'b0; res_r = 1'b0; res_l = 1'b0;
    end
  endtask

  // Result beats that must not be counted: no LAST, then no READY.
  task automatic send_junk();
    @(posedge clk); #1;
    res_v = 1'b1; res_r = 1'b1; res_l = 1'b0;
    @(posedge clk); #1;
    res_v = 1'b1; res_r = 1'b0; res_l = 1'b1;
    @(posedge clk); #1;
    res_v = 1'b0; res_r = 1'b0; res_l = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    chk(name, 64'(done_cnt), 64'(1));
    #1;
    chk({name, "_busy_low"}, 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    chk({name, "_single"}, 64'(done_cnt), 64'(1));
  endtask

  task automatic run_t1();
    int lat;
    done_cnt = 0;
    push_t1();
    start_job(32'h100, 12'd4, 12'd4, 4'd2, 4'd2, lat);
    chk("t1_latency", 64'(lat), 64'(4));
    chk("t1_error_clear", 64'(error), 64'(0));
    wait_drained(60, "t1_beats");
    #1;
    chk("t1_busy_drain", 64'(busy), 64'(1));
    send_res(3);
    send_junk();
    repeat (3) @(posedge clk);
    chk("t1_no_early_done", 64'(done_cnt), 64'(0));
    send_res(1);
    wait_done(10, "t1_done");
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 64'(valid), 64'(0));
    chk({name, "_busy"},  64'(busy),  64'(0));
    chk({name, "_done"},  64'(done),  64'(0));
    chk({name, "_error"}, 64'(error), 64'(0));
    chk({name, "_last"},  64'(last),  64'(0));
    chk({name, "_addr"},  64'(addr),  64'(0));
  endtask

  task automatic abort_run(input logic use_init);
    int lat;
    done_cnt = 0;
    push_t1();
    start_job(32'h100, 12'd4, 12'd4, 4'd2, 4'd2, lat);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_q.size() <= 10) break;
    end
    #1;
    if (use_init) begin
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      chk_zero("init_abort");
    end else begin
      rst_n = 1'b0;
      #1;
      chk_zero("rst_abort");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end
    exp_q.delete();
    repeat (4) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    run_t1();
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    run_t1();

`ifndef POOL_SCHED_CEIL_EN
    done_cnt = 0;
    push_win(0, 4, 0, 0, 3);
    push_win(0, 4, 1, 0, 3);
    push_win(0, 4, 0, 1, 3);
    push_win(0, 4, 1, 1, 3);
    start_job(32'h0, 12'd4, 12'd4, 4'd3, 4'd1, lat);
    chk("t2_latency", 64'(lat), 64'(3));
    wait_drained(80, "t2_beats");
    send_res(3);
    repeat (3) @(posedge clk);
    chk("t2_no_early_done", 64'(done_cnt), 64'(0));
    send_res(1);
    wait_done(10, "t2_done");

    done_cnt = 0;
    start_job(32'h0, 12'd4, 12'd4, 4'd5, 4'd1, lat);
    chk("err_done_latency", 64'(lat), 64'(2));
    chk("err_flag", 64'(error), 64'(1));
    repeat (4) @(posedge clk);
    chk("err_sticky", 64'(error), 64'(1));
    chk("err_done_once", 64'(done_cnt), 64'(1));
    run_t1();
`else
    done_cnt = 0;
    begin
      logic [31:0] ct [10];
      logic [9:0]  cl;
      beat_t       b;
      ct = '{32'd0, 32'd1, 32'd5, 32'd6, 32'd2, 32'd3, 32'd7, 32'd8, 32'd4, 32'd9};
      cl = 10'b1010001000;
      for (int i = 0; i < 10; i++) begin
        b.a = ct[i];
        b.l = cl[i];
        exp_q.push_back(b);
      end
    end
    start_job(32'h0, 12'd5, 12'd2, 4'd2, 4'd2, lat);
    chk("ceil_latency", 64'(lat), 64'(4));
    wait_drained(60, "ceil_beats");
    send_res(2);
    repeat (3) @(posedge clk);
    chk("ceil_no_early_done", 64'(done_cnt), 64'(0));
    send_res(1);
    wait_done(10, "ceil_done");
`endif

    tog_en = 1'b1;
    run_t1();
    tog_en = 1'b0;
    #2 ready = 1'b1;

    abort_run(1'b0);
    abort_run(1'b1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pooling_2d_sched.md
Name: pooling_2d_sched

Overview:
- Address sequencer for single-channel 2D max-pooling.
- On GO, walks a feature map stored row-major in a buffer. For each pooling window it emits a stream of element addresses, asserting LAST on the final element of the window.
- The buffer read side converts each address beat into an IN_DATA/IN_VALID/IN_LAST beat for the max-pooling core.
- Counts result beats coming out of the core and raises DONE once every issued window has produced its result.

Parameters:
- ADDR_WIDTH, 32, buffer address width.
- DIM_WIDTH, 12, width of feature-map width/height fields.
- K_WIDTH, 4, width of kernel and stride fields.

Ports:
- CLK  input  1  clock.
- RESET_N  input  1  asynchronous active-low reset.
- INIT  input  1  synchronous clear; same effect as reset.
- GO  input  1  start pulse; sampled only in IDLE.
- BUSY  output  1  high from GO acceptance until DONE.
- DONE  output  1  one-cycle pulse at job end.
- ERROR  output  1  bad config on last GO; sticky until next GO.
- CFG_BASE  input  ADDR_WIDTH  address of element (0,0).
- CFG_WIDTH  input  DIM_WIDTH  map width W.
- CFG_HEIGHT  input  DIM_WIDTH  map height H.
- CFG_KERNEL  input  K_WIDTH  square window size K.
- CFG_STRIDE  input  K_WIDTH  stride S.
- ADDR_DATA  output  ADDR_WIDTH  element address.
- ADDR_VALID  output  1  address beat valid.
- ADDR_READY  input  1  downstream accepts beat.
- ADDR_LAST  output  1  last element of the window.
- RES_VALID  input  1  core OUT_VALID (monitor only).
- RES_READY  input  1  core OUT_READY (monitor only).
- RES_LAST  input  1  core OUT_LAST (monitor only).

Behaviour:
- Reset/INIT: all outputs 0, FSM in IDLE, all counters 0. INIT mid-job aborts the job with no DONE. Reset mid-job behaves identically.
- FSM states: IDLE, SETUP, RUN, DRAIN, FIN.
- IDLE: on GO, latch all CFG_* inputs, clear ERROR, set BUSY, go to SETUP.
- SETUP (1 cycle): checks the latched config.
  - Error if K==0, S==0, K>W or K>H.
  - On error: set ERROR, go to FIN.
  - Otherwise: row0=0, col0=0, kr=0, kc=0, row_base=BASE, go to RUN.
- RUN: ADDR_VALID=1. ADDR_DATA = row_base + kr*W + col0 + kc.
  - kr*W is held in an incremental accumulator (add W per kr step); no multiplier.
  - The beat is held stable until ADDR_VALID&ADDR_READY. Counters advance only on that handshake.
- Element order within a window: kc fastest, then kr.
- ADDR_LAST=1 when kc==K-1 and kr==K-1. On that beat, windows_issued increments.
- Window advance after LAST:
  - col0+=S while col0+S+K<=W.
  - Otherwise col0=0 and row0+=S (row_base+=S*W, accumulated as S additions of W in SETUP-style steps is forbidden; precompute S*W once in SETUP by repeated addition over ≤15 cycles, SETUP extended accordingly).
  - If row0+S+K>H after the last window, go to DRAIN.
- Results: results_seen increments on RES_VALID&RES_READY&RES_LAST in any non-IDLE state.
- DRAIN: wait until results_seen==windows_issued, then go to FIN. If the equality already holds on entry, exit after 1 cycle.
- FIN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- GO outside IDLE is ignored.
- Addresses wrap modulo 2^ADDR_WIDTH.
- Latency: first ADDR_VALID is 2+S cycles after GO.
- Throughput: one beat per cycle when ADDR_READY is held high.

Optional Feature:
- Macro: POOL_SCHED_CEIL_EN.
- Defined (ceil mode): windows start at every col0<W and row0<H in steps of S. Windows are clipped to cols col0..min(col0+K,W)-1 and rows row0..min(row0+K,H)-1. ADDR_LAST is on the last in-bounds element. The K>W and K>H checks are dropped.
- Undefined (floor mode): the behaviour above.

Decomposition:
- Package pooling_sched_pkg: FSM state encoding constants, ERROR code constant, default widths.
- One sub-module, pooling_2d_sched_cnt: the nested kc/kr/col0/row0 counter with its address accumulator. The top level holds the FSM and the result counter.

Test Plan:
- W=4, H=4, K=2, S=2, BASE=0x100, ADDR_READY=1 -> 16 beats: 0x100, 0x101, 0x104, 0x105(LAST), 0x102, 0x103, 0x106, 0x107(LAST), then the 0x108 and 0x10A windows. After 4 RES_LAST beats, DONE pulses.
- W=4, H=4, K=3, S=1 -> 4 windows, 36 beats. First window ends at 0x0A, last window is 5, 6, 7, 9…0x0F. DONE only after the 4th RES_LAST.
- Same as the first test, with ADDR_READY toggling 1/0 -> identical address sequence, ADDR_DATA stable while stalled, no beat lost or duplicated.
- K=5, W=4 -> ERROR=1, DONE pulses 2 cycles after GO, no ADDR_VALID. A following valid GO clears ERROR.
- RESET_N low (then INIT high, separately) at beat 7 of the first test -> all outputs 0 at once, IDLE, no DONE. A new GO restarts from 0x100.
- POOL_SCHED_CEIL_EN, W=5, H=2, K=2, S=2, BASE=0 -> windows {0,1,5,6}, {2,3,7,8}, {4,9}. LAST on 6, 8 and 9.
